and_gate_sequencer: RTL and testbench



---
 rtl/and_gate_sequencer.sv | 145 ++++++++++++++
 tb/tb_and_gate_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_sequencer.sv
// and_gate_sequencer: self-test controller for a two-input AND gate.
// On start, walks a/b through 00,01,10,11, holding each vector for TICK_DIV
// cycles, samples the synchronised gate output at the end of each window and
// reports a per-vector fail mask plus a pass flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a run (accepted only in IDLE)
//   x          gate output under test (asynchronous, 2-flop synchronised)
//   a, b       gate inputs (registered)
//   busy       high while a run is in progress
//   done       one-cycle pulse when a run completes
//   pass       last completed run had no mismatches
//   fail_mask  bit i set when vector i mismatched
//   step       index of the vector currently applied
module and_gate_sequencer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] step
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_d;
  logic [3:0]       mask_d;
  logic             pass_d, a_d, b_d, busy_d, done_d;
  logic             x_meta, x_sync;

  // Two-flop synchroniser for the gate output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_meta <= 1'b0;
      x_sync <= 1'b0;
    end else begin
      x_meta <= x;
      x_sync <= x_meta;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      step      <= 2'd0;
      fail_mask <= 4'd0;
      pass      <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step      <= step_d;
      fail_mask <= mask_d;
      pass      <= pass_d;
      a         <= a_d;
      b         <= b_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step;
    mask_d  = fail_mask;
    pass_d  = pass;
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          step_d  = 2'd0;
          mask_d  = 4'd0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        a_d    = step[1];
        b_d    = step[0];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // End of hold window: the applied vector equals step
          if (x_sync != (step[1] & step[0])) begin
            mask_d = fail_mask | (4'b0001 << step);
          end
          cnt_d = '0;
          if (step == 2'd3) begin
            state_d = S_REPORT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            a_d     = 1'b0;
            b_d     = 1'b0;
            pass_d  = ~|mask_d;
          end else begin
            step_d = step + 2'd1;
            a_d    = step_d[1];
            b_d    = step_d[0];
          end
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_and_gate_sequencer.sv
// Directed testbench for and_gate_sequencer with TICK_DIV=4.
module tb_and_gate_sequencer;

  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       x;
  logic       a, b, busy, done, pass;
  logic [3:0] fail_mask;
  logic [1:0] step;

  int   checks = 0;
  int   passes = 0;
  int   mode;    // 0 AND, 1 stuck0, 2 stuck1, 3 OR, 4 XOR, 5 stuck0 + glitch
  logic glitch;

  always #5 clk = ~clk;

  // Gate model under test
  always_comb begin
    case (mode)
      0:       x = a & b;
      1:       x = 1'b0;
      2:       x = 1'b1;
      3:       x = a | b;
      4:       x = a ^ b;
      default: x = glitch;
    endcase
  end

  and_gate_sequencer #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .step(step)
  );

  // Pulse start for one cycle; returns at the negedge of the first RUN cycle
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Count cycles from the first RUN cycle (=1) until done; bounded
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 0; glitch = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, busy, done, pass} !== 5'b0) $display("FAIL reset_ctl: got %b required 00000", {a, b, busy, done, pass});
    else passes++;
    checks++;
    if ({fail_mask, step} !== 6'b0) $display("FAIL reset_mask_step: got %b required 000000", {fail_mask, step});
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct();
    logic [1:0] ev;
    mode = 0;
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      ev = 2'((c - 1) / 4);
      checks++;
      if ({a, b, busy, done, step} !== {ev, 1'b1, 1'b0, ev})
        $display("FAIL correct_seq cyc%0d: got a,b,busy,done,step=%b required %b", c, {a, b, busy, done, step}, {ev, 1'b1, 1'b0, ev});
      else passes++;
      @(negedge clk);
    end
    checks++;
    if ({done, busy, a, b} !== 4'b1000) $display("FAIL correct_done17: got done,busy,a,b=%b required 1000", {done, busy, a, b});
    else passes++;
    checks++;
    if ({pass, fail_mask} !== 5'b10000) $display("FAIL correct_result: got pass,mask=%b required 10000", {pass, fail_mask});
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, busy, pass, fail_mask} !== 7'b0010000) $display("FAIL correct_hold: got done,busy,pass,mask=%b required 0010000", {done, busy, pass, fail_mask});
    else passes++;
  endtask

  task automatic test_faults();
    int         modes[4] = '{1, 2, 3, 4};
    logic [3:0] masks[4] = '{4'b1000, 4'b0111, 4'b0110, 4'b1110};
    int         cyc;
    for (int i = 0; i < 4; i++) begin
      mode = modes[i];
      pulse_start();
      wait_done(cyc);
      checks++;
      if (cyc !== 17) $display("FAIL fault%0d_done_cycle: got %0d required 17", mode, cyc);
      else passes++;
      checks++;
      if (fail_mask !== masks[i]) $display("FAIL fault%0d_mask: got %b required %b", mode, fail_mask, masks[i]);
      else passes++;
      checks++;
      if (pass !== 1'b0) $display("FAIL fault%0d_pass: got %b required 0", mode, pass);
      else passes++;
    end
  endtask

  // x pulses high during the first cycle of each window; only the end-of-window sample counts
  task automatic test_glitch();
    mode = 5; glitch = 1'b0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
      repeat (3) @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) $display("FAIL glitch_done: got %b required 1", done);
    else passes++;
    checks++;
    if ({pass, fail_mask} !== 5'b01000) $display("FAIL glitch_result: got pass,mask=%b required 01000", {pass, fail_mask});
    else passes++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone = 0;
    int dcyc  = 0;
    mode = 1;
    pulse_start();
    wait_done(cyc);
    checks++;
    if (fail_mask !== 4'b1000) $display("FAIL b2b_run1_mask: got %b required 1000", fail_mask);
    else passes++;
    mode = 0;
    pulse_start();
    checks++;
    if ({pass, fail_mask} !== 5'b0) $display("FAIL b2b_clear_on_start: got pass,mask=%b required 00000", {pass, fail_mask});
    else passes++;
    for (int c = 1; c <= 25; c++) begin
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
      end
      start = (c == 5 || c == 17);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || dcyc !== 17) $display("FAIL b2b_single_done: got count=%0d at cyc %0d required 1 at 17", ndone, dcyc);
    else passes++;
    checks++;
    if ({busy, pass, fail_mask} !== 6'b010000) $display("FAIL b2b_result: got busy,pass,mask=%b required 010000", {busy, pass, fail_mask});
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int nd = 0;
    mode = 2;
    pulse_start();
    repeat (9) @(negedge clk);
    checks++;
    if ({step, fail_mask} !== 6'b100011) $display("FAIL midrun_pre: got step,mask=%b required 100011", {step, fail_mask});
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, busy, done, pass, fail_mask, step} !== 11'b0) $display("FAIL midrun_async_reset: got %b required all zero", {a, b, busy, done, pass, fail_mask, step});
    else passes++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    checks++;
    if (nd !== 0 || busy !== 1'b0) $display("FAIL midrun_no_done: got done count=%0d busy=%b required 0,0", nd, busy);
    else passes++;
    mode = 0;
    pulse_start();
    checks++;
    if ({busy, step, a, b} !== 5'b10000) $display("FAIL midrun_restart: got busy,step,a,b=%b required 10000", {busy, step, a, b});
    else passes++;
    wait_done(cyc);
    checks++;
    if (cyc !== 17 || pass !== 1'b1 || fail_mask !== 4'b0)
      $display("FAIL midrun_rerun: got cyc=%0d pass=%b mask=%b required 17,1,0000", cyc, pass, fail_mask);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_correct();
    test_faults();
    test_glitch();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
